// File: rtl/fifo_rdout_ctrl.sv
// Sequences header and channel-FIFO pops for one sample at a time.
// Header pop 1 cycle after start; data words qualified 1 cycle after each pop.
// DS_AFULL only gates new samples; a started sample always finishes or aborts.
module fifo_rdout_ctrl #(
    parameter int NWORDS = 6
) (
    input  logic        RDCLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        RDY,
    input  logic        EVT_END,
    input  logic [15:0] FMT,
    input  logic [15:0] CH_MASK,
    input  logic [6:0]  SAMP_MAX,
    input  logic        DS_AFULL,
    output logic        L1A_RD_EN,
    output logic [15:0] RD_ENA,
    output logic        HDR_VALID,
    output logic        DATA_VALID,
    output logic [2:0]  WORD_IDX,
    output logic [6:0]  SMP_IDX,
    output logic        EVT_DONE,
    output logic        BUSY,
    output logic        UNDERRUN,
    output logic        FRAME_ERR,
    output logic [15:0] EVT_CNT
);

    localparam logic [2:0] LAST_WORD = 3'(NWORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_W1,
        HDR_W2,
        DATA
    } state_t;

    state_t      state;
    logic [2:0]  word_cnt;
    logic        evt_end_q;
    logic [15:0] evt_cnt_q;
    logic        underrun_now;

    // An empty enabled channel must suppress the pop in the same cycle, so RD_ENA is combinational.
    assign underrun_now = (state == DATA) && (|(FMT & CH_MASK));
    assign RD_ENA       = ((state == DATA) && !underrun_now) ? CH_MASK : 16'h0000;
    assign EVT_CNT      = evt_cnt_q;

    always_ff @(posedge RDCLK) begin
        if (RST) begin
            state      <= IDLE;
            L1A_RD_EN  <= 1'b0;
            HDR_VALID  <= 1'b0;
            DATA_VALID <= 1'b0;
            EVT_DONE   <= 1'b0;
            BUSY       <= 1'b0;
            WORD_IDX   <= 3'd0;
            SMP_IDX    <= 7'd0;
            evt_cnt_q  <= 16'h0000;
            UNDERRUN   <= 1'b0;
            FRAME_ERR  <= 1'b0;
            word_cnt   <= 3'd0;
            evt_end_q  <= 1'b0;
        end else begin
            L1A_RD_EN  <= 1'b0;
            HDR_VALID  <= 1'b0;
            DATA_VALID <= 1'b0;
            EVT_DONE   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ENABLE && RDY && !DS_AFULL) begin
                        state     <= HDR_RD;
                        L1A_RD_EN <= 1'b1;
                        BUSY      <= 1'b1;
                    end
                end
                HDR_RD: begin
                    state     <= HDR_W1;
                    HDR_VALID <= 1'b1;
                end
                HDR_W1: state <= HDR_W2;
                HDR_W2: begin
                    evt_end_q <= EVT_END;
                    word_cnt  <= 3'd0;
                    state     <= DATA;
                end
                DATA: begin
                    if (underrun_now) begin
                        UNDERRUN <= 1'b1;
                        SMP_IDX  <= 7'd0;
                        state    <= IDLE;
                        BUSY     <= 1'b0;
                    end else begin
                        DATA_VALID <= 1'b1;
                        WORD_IDX   <= word_cnt;
                        if (word_cnt == LAST_WORD) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                            if (evt_end_q) begin
                                EVT_DONE  <= 1'b1;
                                evt_cnt_q <= evt_cnt_q + 16'd1;
                                SMP_IDX   <= 7'd0;
                            end else if (SMP_IDX == SAMP_MAX) begin
                                // Header stream ran past the configured sample count without an end flag.
                                FRAME_ERR <= 1'b1;
                                SMP_IDX   <= 7'd0;
                            end else begin
                                SMP_IDX <= SMP_IDX + 7'd1;
                            end
                        end else begin
                            word_cnt <= word_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
